// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares the single write port of a synchronous FIFO
// between NUM_REQ valid/ready producers. Round-robin selection, grants held
// for up to MAX_BURST beats, one IDLE bubble between grants, and no write is
// issued while fifo_full is high.
// Optional build macro FIFO_ARB_STRICT_PRIO_EN: when defined, IDLE selection
// is fixed priority (lowest index wins) instead of round-robin.
module fifo_write_arbiter #(
  parameter int WIDTH     = 4,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_write,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  last_grant, grant_nxt, last_nxt, pick;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             transfer;

  // Choose the next grantee among the active requesters.
`ifdef FIFO_ARB_STRICT_PRIO_EN
  function automatic logic [ID_W-1:0] select(input logic [NUM_REQ-1:0] valid);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction
`else
  function automatic logic [ID_W-1:0] select(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] idx;
    logic            found;
    int              i;
    idx   = '0;
    found = 1'b0;
    // Search upward from the port after the last grantee, wrapping to 0.
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = (int'(last) + k) % NUM_REQ;
      if (!found && valid[i]) begin
        idx   = ID_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction
`endif

  // State, grant and beat counter registers; reset aborts any burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
      beat_cnt   <= cnt_nxt;
    end
  end

  // Next-state logic plus the combinational handshake and FIFO write path.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_id;
    last_nxt     = last_grant;
    cnt_nxt      = beat_cnt;
    req_ready    = '0;
    fifo_write   = 1'b0;
    fifo_data_in = '0;
    busy         = 1'b0;
    transfer     = 1'b0;
`ifdef FIFO_ARB_STRICT_PRIO_EN
    pick         = select(req_valid);
`else
    pick         = select(req_valid, last_grant);
`endif
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_nxt = pick;
          last_nxt  = pick;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        busy                = 1'b1;
        req_ready[grant_id] = ~fifo_full;
        transfer            = req_valid[grant_id] & ~fifo_full;
        fifo_write          = transfer;
        fifo_data_in        = req_data[int'(grant_id)*WIDTH +: WIDTH];
        if (transfer) begin
          cnt_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) state_nxt = IDLE;
        end else if (!req_valid[grant_id]) begin
          // Producer went quiet: release the port early.
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
